// File: rtl/clock_display_driver_pkg.sv
// clock_display_driver_pkg: shared digit count, blank code, FSM states and 7-segment decode
package clock_display_driver_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // {g,f,e,d,c,b,a}, active-low, digits 0..9
  localparam logic [6:0] SEG_TABLE [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CONV = 2'd1, ST_COMMIT = 2'd2} state_e;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : SEG_TABLE[d];
  endfunction
endpackage

// File: rtl/clock_display_driver_bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble of a 6-bit value into two BCD digits over 6 cycles
// Ports: clk_i/reset_i (async, active-high); start_i loads bin_i and performs the first shift;
//   done_o is high once all six shift/add-3 steps are complete; tens_o/ones_o hold the result.
module bin_to_bcd_seq (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [5:0] bin_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);
  logic [5:0] sr_q;
  logic [3:0] tens_q, ones_q, tens_adj, ones_adj;
  logic [2:0] cnt_q;
  assign tens_adj = tens_q >= 4'd5 ? tens_q + 4'd3 : tens_q;
  assign ones_adj = ones_q >= 4'd5 ? ones_q + 4'd3 : ones_q;
  assign done_o = cnt_q == 3'd6;
  assign tens_o = tens_q;
  assign ones_o = ones_q;
  // the first step needs no add-3 (BCD starts at zero), so it is folded into the load
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sr_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      tens_q <= '0;
      ones_q <= {3'b000, bin_i[5]};
      sr_q <= {bin_i[4:0], 1'b0};
      cnt_q <= 3'd1;
    end else if (cnt_q != 3'd0 && cnt_q != 3'd6) begin
      {tens_q, ones_q, sr_q} <= {tens_adj[2:0], ones_adj, sr_q, 1'b0};
      cnt_q <= cnt_q + 3'd1;
    end
  end
endmodule

// File: rtl/clock_display_driver.sv
// clock_display_driver: latches a time, converts it to BCD and scans six active-low 7-segment digits
// Ports: clk_i/reset_i (async, active-high); hour_i/min_i/sec_i binary time sampled on load_i;
//   blink_i blinks the whole display; busy_o flags a conversion (load_i ignored);
//   an_o one-hot active-low anodes (bit0 = seconds ones); seg_o {g..a} and dp_o active-low.
module clock_display_driver #(
  parameter int SCAN_DIV      = 100_000,
  parameter int BLINK_DIV     = 250,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic       load_i,
  input  logic       blink_i,
  output logic       busy_o,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);
  import clock_display_driver_pkg::*;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  state_e state_q;
  logic busy_q, cv_start, cv_done, tick, blank5, phase_q, dp_q, dp_d;
  logic [1:0] fld_q;
  logic [2:0] bit_q, idx_q;
  logic [5:0] sc_q, mn_q, hr_q, cv_bin, an_q, an_d;
  logic [7:0] sec_bcd_q, min_bcd_q;
  logic [3:0] cv_tens, cv_ones, dig;
  logic [3:0] disp_q [NUM_DIGITS];
  logic [SW-1:0] scan_q;
  logic [BW-1:0] blk_q;
  logic [6:0] seg_q, seg_d;
  // one converter serves sec, min, hour in turn; each field owns 6 CONV cycles
  assign cv_start = state_q == ST_CONV && bit_q == 3'd0;
  assign cv_bin = fld_q == 2'd0 ? sc_q : fld_q == 2'd1 ? mn_q : hr_q;
  bin_to_bcd_seq u_bcd (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .start_i(cv_start),
    .bin_i  (cv_bin),
    .done_o (cv_done),
    .tens_o (cv_tens),
    .ones_o (cv_ones)
  );
  // a field's result is still in the converter when the next field starts, so it is staged then
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      busy_q <= 1'b0;
      fld_q <= '0;
      bit_q <= '0;
      sc_q <= '0;
      mn_q <= '0;
      hr_q <= '0;
      sec_bcd_q <= '0;
      min_bcd_q <= '0;
      disp_q <= '{default: 4'd0};
    end else begin
      case (state_q)
        ST_IDLE: if (load_i) begin
          sc_q <= sec_i;
          mn_q <= min_i;
          hr_q <= {1'b0, hour_i};
          fld_q <= '0;
          bit_q <= '0;
          busy_q <= 1'b1;
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          if (cv_start && fld_q == 2'd1) sec_bcd_q <= {cv_tens, cv_ones};
          if (cv_start && fld_q == 2'd2) min_bcd_q <= {cv_tens, cv_ones};
          bit_q <= bit_q == 3'd5 ? 3'd0 : bit_q + 3'd1;
          fld_q <= bit_q == 3'd5 ? fld_q + 2'd1 : fld_q;
          state_q <= bit_q == 3'd5 && fld_q == 2'd2 ? ST_COMMIT : ST_CONV;
        end
        ST_COMMIT: begin
          if (cv_done) disp_q <= '{sec_bcd_q[3:0], sec_bcd_q[7:4], min_bcd_q[3:0],
                                   min_bcd_q[7:4], cv_ones, cv_tens};
          busy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign tick = scan_q == SW'(SCAN_DIV - 1);
  assign dig = disp_q[idx_q];
  assign blank5 = BLANK_LEADING && idx_q == 3'd5 && disp_q[5] == 4'd0;
  assign an_d = blank5 || !phase_q ? 6'h3F : ~(6'd1 << idx_q);
  assign seg_d = blank5 ? SEG_BLANK : seg_decode(dig);
  assign dp_d = !(idx_q == 3'd2 || idx_q == 3'd4);
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scan_q <= '0;
      idx_q <= '0;
      blk_q <= '0;
      phase_q <= 1'b1;
      an_q <= 6'h3F;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
    end else begin
      scan_q <= tick ? '0 : scan_q + 1'b1;
      if (tick) idx_q <= idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
      if (!blink_i) begin
        blk_q <= '0;
        phase_q <= 1'b1;
      end else if (tick) begin
        blk_q <= blk_q == BW'(BLINK_DIV - 1) ? '0 : blk_q + 1'b1;
        if (blk_q == BW'(BLINK_DIV - 1)) phase_q <= !phase_q;
      end
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign busy_o = busy_q;
  assign an_o = an_q;
  assign seg_o = seg_q;
  assign dp_o = dp_q;
endmodule

// File: tb/tb_clock_display_driver.sv
// tb_clock_display_driver: scoreboard bench for the clock display driver with a fast scan rate
module tb_clock_display_driver;
  localparam int SD = 4;
  logic clk_i = 1'b0, reset_i = 1'b1, load_i = 1'b0, blink_i = 1'b0;
  logic [4:0] hour_i = '0;
  logic [5:0] min_i = '0, sec_i = '0;
  logic busy_o, dp_o;
  logic [5:0] an_o;
  logic [6:0] seg_o;
  int n_checks = 0, n_fail = 0, edges = 0;
  typedef struct {int slot; logic [5:0] an; logic [6:0] seg; logic dp;} exp_t;
  exp_t sbq[$];
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  clock_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(2), .BLANK_LEADING(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
    .load_i(load_i), .blink_i(blink_i), .busy_o(busy_o), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i or posedge reset_i) edges <= reset_i ? 0 : edges + 1;
  function automatic int cur_slot();
    return edges >= 1 ? ((edges - 1) / SD) % 6 : 0;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push_frame(input int h, input int m, input int s, input int start);
    int d[6];
    d = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      bit blank;
      e.slot = (start + k) % 6;
      blank = e.slot == 5 && d[5] == 0;
      e.an = blank ? 6'h3F : ~(6'd1 << e.slot);
      e.seg = blank ? 7'h7F : seg_tab[d[e.slot]];
      e.dp = !(e.slot == 2 || e.slot == 4);
      sbq.push_back(e);
    end
  endtask
  task automatic drain();
    int t = 0;
    while (sbq.size() > 0 && t < 80) begin
      @(negedge clk_i);
      t++;
    end
    if (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d slots never presented, expected 0", sbq.size());
      sbq.delete();
    end
  endtask
  task automatic do_load(input int h, input int m, input int s, output int bc);
    hour_i = 5'(h);
    min_i = 6'(m);
    sec_i = 6'(s);
    load_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    load_i = 1'b0;
    bc = 0;
    while (busy_o && bc < 100) begin
      bc++;
      @(negedge clk_i);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk_i);
      if (!reset_i && edges >= 1 && sbq.size() > 0 && sbq[0].slot == cur_slot()) begin
        exp_t e;
        e = sbq.pop_front();
        check($sformatf("slot%0d_an", e.slot), 32'(an_o), 32'(e.an));
        check($sformatf("slot%0d_seg", e.slot), 32'(seg_o), 32'(e.seg));
        check($sformatf("slot%0d_dp", e.slot), 32'(dp_o), 32'(e.dp));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end
  initial begin
    int bc, offc, run, maxrun, onc;
    repeat (2) @(negedge clk_i);
    check("rst_an", 32'(an_o), 32'h3F);
    check("rst_seg", 32'(seg_o), 32'h7F);
    check("rst_dp", 32'(dp_o), 32'h1);
    check("rst_busy", 32'(busy_o), 32'h0);
    reset_i = 1'b0;
    push_frame(0, 0, 0, 0);
    drain();
    do_load(12, 34, 56, bc);
    check("busy_12_34_56", 32'(bc), 32'd19);
    push_frame(12, 34, 56, (cur_slot() + 1) % 6);
    drain();
    do_load(9, 5, 0, bc);
    check("busy_9_05_00", 32'(bc), 32'd19);
    push_frame(9, 5, 0, (cur_slot() + 1) % 6);
    drain();
    hour_i = 5'd1;
    min_i = 6'd0;
    sec_i = 6'd0;
    load_i = 1'b1;
    @(posedge clk_i);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      load_i = i == 4;
      if (i == 4) hour_i = 5'd2;
      bc += int'(busy_o);
    end
    check("busy_dropped_load", 32'(bc), 32'd19);
    push_frame(1, 0, 0, (cur_slot() + 1) % 6);
    drain();
    do_load(31, 63, 63, bc);
    check("busy_31_63_63", 32'(bc), 32'd19);
    push_frame(31, 63, 63, (cur_slot() + 1) % 6);
    drain();
    do_load(12, 34, 56, bc);
    blink_i = 1'b1;
    repeat (20) @(negedge clk_i);
    offc = 0;
    run = 0;
    maxrun = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      run = an_o == 6'h3F ? run + 1 : 0;
      offc += int'(an_o == 6'h3F);
      maxrun = run > maxrun ? run : maxrun;
    end
    check("blink_off_cycles", 32'(offc), 32'd16);
    check("blink_off_run", 32'(maxrun), 32'd8);
    blink_i = 1'b0;
    repeat (3) @(negedge clk_i);
    offc = 0;
    onc = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk_i);
      offc += int'(an_o == 6'h3F);
      onc += int'($countones(~an_o) == 1);
    end
    check("noblink_off_cycles", 32'(offc), 32'd0);
    check("noblink_onehot_cycles", 32'(onc), 32'd48);
    hour_i = 5'd11;
    min_i = 6'd59;
    sec_i = 6'd59;
    load_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    load_i = 1'b0;
    repeat (9) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_an", 32'(an_o), 32'h3F);
    check("midrst_seg", 32'(seg_o), 32'h7F);
    check("midrst_dp", 32'(dp_o), 32'h1);
    check("midrst_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    push_frame(0, 0, 0, 0);
    drain();
    do_load(8, 47, 13, bc);
    check("busy_after_reset", 32'(bc), 32'd19);
    push_frame(8, 47, 13, (cur_slot() + 1) % 6);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
